// File: rtl/qbus_pkg.sv
// Shared QBUS definitions: DMA requester state encoding and bus level constants.
// Bus signals are active-low levels, so ASSERTED is 0 and NEGATED is 1.
package qbus_pkg;

    localparam logic ASSERTED = 1'b0;
    localparam logic NEGATED  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PASS   = 3'd1,
        REQ    = 3'd2,
        ACK    = 3'd3,
        MASTER = 3'd4,
        REL    = 3'd5
    } dma_state_e;

endpackage

// File: rtl/qbus_sync.sv
// Multi-flop synchronizer for one asynchronous, active-low QBUS input.
// Ports: clk, reset (async, active-high, flops preset to 1 = negated), d (raw), q (synced).
module qbus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;
    logic [STAGES-1:0] ff_d;

    always_comb begin
        ff_d = {ff_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff_q <= '1;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/qbus_dma_requester.sv
// QBUS DMA bus requester: raises BDMR, absorbs or passes the grant chain, asserts BSACK,
// waits for bus idle and hands mastership to the local engine until dma_done.
// Ports: clk, reset; bus inputs BINIT/BDMGI/BSYNC/BRPLY (async, active-low);
// bus outputs BDMR/BSACK/BDMGO (active-low); engine side dma_req, dma_done, dma_grant,
// dma_timeout.
module qbus_dma_requester
    import qbus_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int GRANT_TIMEOUT = 1024,
    parameter int TMO_W         = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic BINIT,
    input  logic BDMGI,
    input  logic BSYNC,
    input  logic BRPLY,
    output logic BDMR,
    output logic BSACK,
    output logic BDMGO,
    input  logic dma_req,
    input  logic dma_done,
    output logic dma_grant,
    output logic dma_timeout
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GRANT_TIMEOUT - 1);

    logic gi;
    logic sy;
    logic rp;
    logic in_sync;

    dma_state_e       state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             bdmr_q, bdmr_d;
    logic             bsack_q, bsack_d;
    logic             bdmgo_q, bdmgo_d;
    logic             grant_q, grant_d;
    logic             tmo_q, tmo_d;

    qbus_sync #(.STAGES(SYNC_STAGES)) u_sync_init (
        .clk(clk), .reset(reset), .d(BINIT), .q(in_sync)
    );
    qbus_sync #(.STAGES(SYNC_STAGES)) u_sync_dmgi (
        .clk(clk), .reset(reset), .d(BDMGI), .q(gi)
    );
    qbus_sync #(.STAGES(SYNC_STAGES)) u_sync_sync (
        .clk(clk), .reset(reset), .d(BSYNC), .q(sy)
    );
    qbus_sync #(.STAGES(SYNC_STAGES)) u_sync_rply (
        .clk(clk), .reset(reset), .d(BRPLY), .q(rp)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        bdmgo_d = NEGATED;

        if (in_sync == ASSERTED) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    bdmgo_d = gi;
                    // A grant arriving while idle belongs downstream, even
                    // if a local request shows up in the same cycle.
                    if (gi == ASSERTED) begin
                        state_d = PASS;
                    end else if (dma_req) begin
                        state_d = REQ;
                        cnt_d   = '0;
                    end
                end
                PASS: begin
                    bdmgo_d = gi;
                    if (gi == NEGATED) begin
                        state_d = IDLE;
                    end
                end
                REQ: begin
                    if (gi == ASSERTED) begin
                        state_d = ACK;
                    end else if (!dma_req) begin
                        state_d = IDLE;
                    end else if (cnt_q == TMO_LAST) begin
                        state_d = IDLE;
                        tmo_d   = 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + TMO_W'(1);
                    end
                end
                ACK: begin
                    if (sy == NEGATED && rp == NEGATED) begin
                        state_d = MASTER;
                    end
                end
                MASTER: begin
                    if (dma_done) begin
                        state_d = REL;
                    end
                end
                REL: begin
                    if (gi == NEGATED) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Bus outputs follow the next state, so BDMR and BSACK can never
        // be asserted together and change on the same edge as the state.
        bdmr_d  = (state_d == REQ) ? ASSERTED : NEGATED;
        bsack_d = (state_d == ACK || state_d == MASTER) ? ASSERTED : NEGATED;
        grant_d = (state_d == MASTER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bdmr_q  <= NEGATED;
            bsack_q <= NEGATED;
            bdmgo_q <= NEGATED;
            grant_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bdmr_q  <= bdmr_d;
            bsack_q <= bsack_d;
            bdmgo_q <= bdmgo_d;
            grant_q <= grant_d;
            tmo_q   <= tmo_d;
        end
    end

    assign BDMR        = bdmr_q;
    assign BSACK       = bsack_q;
    assign BDMGO       = bdmgo_q;
    assign dma_grant   = grant_q;
    assign dma_timeout = tmo_q;

endmodule

// File: tb/tb_qbus_dma_requester.sv
// Testbench for qbus_dma_requester: directed latency scenarios plus random
// bus traffic checked every cycle against a behavioural ownership model.
module tb_qbus_dma_requester;

    localparam int GT = 16;

    logic clk = 1'b0;
    logic reset;
    logic BINIT, BDMGI, BSYNC, BRPLY;
    logic BDMR, BSACK, BDMGO;
    logic dma_req, dma_done;
    logic dma_grant, dma_timeout;

    int checks = 0;
    int failures = 0;

    qbus_dma_requester #(
        .SYNC_STAGES(2),
        .GRANT_TIMEOUT(GT),
        .TMO_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .BINIT(BINIT),
        .BDMGI(BDMGI),
        .BSYNC(BSYNC),
        .BRPLY(BRPLY),
        .BDMR(BDMR),
        .BSACK(BSACK),
        .BDMGO(BDMGO),
        .dma_req(dma_req),
        .dma_done(dma_done),
        .dma_grant(dma_grant),
        .dma_timeout(dma_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural model: who holds the bus, from this device's viewpoint.
    localparam int P_IDLE = 0;  // nothing going on
    localparam int P_DOWN = 1;  // grant flowing to a downstream device
    localparam int P_WAIT = 2;  // asking the arbiter
    localparam int P_GOT  = 3;  // grant taken, previous master still busy
    localparam int P_OWN  = 4;  // local engine owns the bus
    localparam int P_DONE = 5;  // finished, waiting for arbiter to drop grant

    int   ph;
    int   waited;
    logic [1:0] h_gi, h_sy, h_rp, h_in;
    logic m_bdmgo, m_tmo;
    logic m_bdmr, m_bsack, m_grant;

    assign m_bdmr  = (ph == P_WAIT) ? 1'b0 : 1'b1;
    assign m_bsack = (ph == P_GOT || ph == P_OWN) ? 1'b0 : 1'b1;
    assign m_grant = (ph == P_OWN);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph = P_IDLE;
            waited = 0;
            h_gi = 2'b11; h_sy = 2'b11; h_rp = 2'b11; h_in = 2'b11;
            m_bdmgo = 1'b1;
            m_tmo = 1'b0;
        end else begin
            logic g, s, r, i;
            g = h_gi[1]; s = h_sy[1]; r = h_rp[1]; i = h_in[1];
            m_tmo = 1'b0;
            if (!i) begin
                ph = P_IDLE;
                m_bdmgo = 1'b1;
            end else begin
                m_bdmgo = (ph == P_IDLE || ph == P_DOWN) ? g : 1'b1;
                if (ph == P_IDLE) begin
                    if (!g) ph = P_DOWN;
                    else if (dma_req) begin ph = P_WAIT; waited = 0; end
                end else if (ph == P_DOWN) begin
                    if (g) ph = P_IDLE;
                end else if (ph == P_WAIT) begin
                    if (!g) ph = P_GOT;
                    else if (!dma_req) ph = P_IDLE;
                    else begin
                        waited++;
                        if (waited == GT) begin ph = P_IDLE; m_tmo = 1'b1; end
                    end
                end else if (ph == P_GOT) begin
                    if (s && r) ph = P_OWN;
                end else if (ph == P_OWN) begin
                    if (dma_done) ph = P_DONE;
                end else begin
                    if (g) ph = P_IDLE;
                end
            end
            h_gi = {h_gi[0], BDMGI};
            h_sy = {h_sy[0], BSYNC};
            h_rp = {h_rp[0], BRPLY};
            h_in = {h_in[0], BINIT};
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("cmp_bdmr", BDMR, m_bdmr);
            chk("cmp_bsack", BSACK, m_bsack);
            chk("cmp_bdmgo", BDMGO, m_bdmgo);
            chk("cmp_grant", dma_grant, m_grant);
            chk("cmp_tmo", dma_timeout, m_tmo);
            if (!BDMR && !BSACK) chk("bdmr_bsack_excl", 1'b1, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_bdmr"}, BDMR, 1'b1);
        chk({nm, "_bsack"}, BSACK, 1'b1);
        chk({nm, "_bdmgo"}, BDMGO, 1'b1);
        chk({nm, "_grant"}, dma_grant, 1'b0);
        chk({nm, "_tmo"}, dma_timeout, 1'b0);
    endtask

    initial begin
        int binit_left;
        reset = 1'b1;
        BINIT = 1'b1; BDMGI = 1'b1; BSYNC = 1'b1; BRPLY = 1'b1;
        dma_req = 1'b0; dma_done = 1'b0;
        #1;
        chk_reset_vals("rst");
        tick(); tick();
        reset = 1'b0;
        tick(); tick();

        // Request, grant with idle bus, release.
        dma_req = 1'b1;
        tick();
        chk("t1_bdmr_low", BDMR, 1'b0);
        chk("t1_model_bdmr", m_bdmr, 1'b0);
        BDMGI = 1'b0;
        tick(); tick();
        chk("t1_bsack_t2", BSACK, 1'b1);
        tick();
        chk("t1_bsack_t3", BSACK, 1'b0);
        chk("t1_bdmr_t3", BDMR, 1'b1);
        chk("t1_grant_t3", dma_grant, 1'b0);
        tick();
        chk("t1_grant_t4", dma_grant, 1'b1);
        chk("t1_model_grant", m_grant, 1'b1);
        dma_req = 1'b0;

        // Done, then a new request while the grant is still present.
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk("t5_grant_off", dma_grant, 1'b0);
        chk("t5_bsack_off", BSACK, 1'b1);
        dma_req = 1'b1;
        repeat (5) tick();
        chk("t5_no_bdmr", BDMR, 1'b1);
        BDMGI = 1'b1;
        repeat (3) tick();
        chk("t5_bdmr_still_high", BDMR, 1'b1);
        tick();
        chk("t5_bdmr_low", BDMR, 1'b0);

        // No grant: timeout 16 cycles after entering the request state.
        repeat (15) tick();
        chk("t4_tmo_early", dma_timeout, 1'b0);
        chk("t4_bdmr_held", BDMR, 1'b0);
        tick();
        chk("t4_tmo_pulse", dma_timeout, 1'b1);
        chk("t4_bdmr_back", BDMR, 1'b1);
        chk("t4_model_tmo", m_tmo, 1'b1);
        dma_req = 1'b0;
        tick();
        chk("t4_tmo_one_clk", dma_timeout, 1'b0);

        // Grant while the previous master still holds SYNC.
        BSYNC = 1'b0;
        dma_req = 1'b1;
        tick();
        chk("t2_bdmr_low", BDMR, 1'b0);
        BDMGI = 1'b0;
        repeat (3) tick();
        chk("t2_bsack_low", BSACK, 1'b0);
        repeat (4) tick();
        chk("t2_wait_grant", dma_grant, 1'b0);
        chk("t2_wait_bsack", BSACK, 1'b0);
        BSYNC = 1'b1;
        tick(); tick();
        chk("t2_grant_u2", dma_grant, 1'b0);
        tick();
        chk("t2_grant_u3", dma_grant, 1'b1);
        dma_req = 1'b0;
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        BDMGI = 1'b1;
        repeat (4) tick();

        // Grant passes through, local request waits for it to go away.
        BDMGI = 1'b0;
        tick(); tick();
        chk("t3_bdmgo_t2", BDMGO, 1'b1);
        tick();
        chk("t3_bdmgo_t3", BDMGO, 1'b0);
        dma_req = 1'b1;
        repeat (4) tick();
        chk("t3_bdmr_blocked", BDMR, 1'b1);
        chk("t3_bdmgo_kept", BDMGO, 1'b0);
        BDMGI = 1'b1;
        repeat (3) tick();
        chk("t3_bdmgo_high", BDMGO, 1'b1);
        chk("t3_bdmr_t3", BDMR, 1'b1);
        tick();
        chk("t3_bdmr_low", BDMR, 1'b0);

        // Bus init while master.
        BDMGI = 1'b0;
        repeat (3) tick();
        chk("t6_bsack_low", BSACK, 1'b0);
        tick();
        chk("t6_grant", dma_grant, 1'b1);
        dma_req = 1'b0;
        BINIT = 1'b0;
        tick(); tick();
        chk("t6_grant_pre", dma_grant, 1'b1);
        tick();
        chk_reset_vals("t6_binit");
        repeat (4) tick();
        chk_reset_vals("t6_binit_hold");
        BDMGI = 1'b1;
        tick(); tick();
        BINIT = 1'b1;
        repeat (3) tick();

        // Reset mid-request.
        dma_req = 1'b1;
        tick();
        chk("t6_req_bdmr", BDMR, 1'b0);
        reset = 1'b1;
        #1;
        chk_reset_vals("t6_rst");
        dma_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Random traffic, checked by the compare process each cycle.
        binit_left = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(11) == 0) BDMGI = ~BDMGI;
            BSYNC = ($urandom_range(3) != 0);
            BRPLY = ($urandom_range(3) != 0);
            if (binit_left > 0) binit_left--;
            else if ($urandom_range(299) == 0) binit_left = $urandom_range(6, 1);
            BINIT = (binit_left == 0);
            if (m_grant) dma_req = 1'b0;
            else if (!dma_req && $urandom_range(7) == 0) dma_req = 1'b1;
            else if (dma_req && $urandom_range(79) == 0) dma_req = 1'b0;
            dma_done = ($urandom_range(5) == 0);
        end
        BINIT = 1'b1; BDMGI = 1'b1; dma_req = 1'b0; dma_done = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
